demux_onehot_reg: RTL
=====================

Name: demux_onehot_reg

Overview:
- Parametrised registered successor to the fixed 3-to-8 decoder.
- Decodes an SEL_W-bit channel select into a one-hot channel valid over NUM_CH channels and routes a DATA_W payload to the selected channel.
- Uses a single-entry valid/ready output stage, so the input side is back-pressured by the selected channel.
- Sits between a producer issuing (select, data) transactions and NUM_CH independent consumers.

Parameters:
- SEL_W, 3, width of channel select.
- NUM_CH, 8, number of output channels; legal range 2..2**SEL_W, so non-power-of-2 counts are allowed.
- DATA_W, 8, payload width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, block enable; when 0, no new input is accepted.
- in_valid, input, 1, producer has a transaction.
- in_ready, output, 1, block accepts a transaction this cycle.
- in_sel, input, SEL_W, target channel index.
- in_data, input, DATA_W, payload.
- out_valid, output, NUM_CH, one-hot valid; at most one bit set.
- out_ready, input, NUM_CH, per-channel consumer ready.
- out_data, output, DATA_W, payload shared across all channels; qualified by out_valid.
- err_oor, output, 1, sticky flag: an out-of-range select was received.
- err_clr, input, 1, synchronous clear of err_oor.

Behaviour:
- Reset (async assert, sync deassert at the consumer's discretion):
  - out_valid=0, out_data=0, err_oor=0.
  - Internal state EMPTY; in_ready=0 while rst_n=0.
- States:
  - EMPTY: no held transaction.
  - FULL: holds channel index ch and data.
- drain = FULL && out_ready[ch]. The out_ready bits of non-selected channels are ignored.
- in_ready = en && (EMPTY || drain). It is combinational from en, state and out_ready[ch], and never depends on in_valid.
- accept = in_valid && in_ready.
- In-range accept (in_sel < NUM_CH):
  - Next state FULL; ch<=in_sel; out_data<=in_data.
  - out_valid<=onehot(in_sel) on the next edge, so latency is 1 cycle.
- Out-of-range accept (in_sel >= NUM_CH; possible only when NUM_CH < 2**SEL_W):
  - Transaction is consumed and dropped; err_oor<=1.
  - Next state: EMPTY if drain was true or the state was EMPTY; otherwise unchanged.
- Drain with no accept: FULL->EMPTY, out_valid<=0. out_data retains its last value (don't-care).
- Drain and in-range accept in the same cycle: stays FULL with the new ch/data. Sustained throughput is 1 transaction per cycle.
- While FULL and not draining: out_valid, out_data and ch are held stable. No change is permitted until the handshake completes.
- en=0: in_ready=0, but a held transaction still drains normally. en has no effect on out_valid.
- err_clr and a new out-of-range accept in the same cycle: set wins, err_oor=1.
- Reset mid-operation: the held transaction is discarded immediately (async); no out_valid pulse after release.
- Width rules:
  - in_sel is compared unsigned against NUM_CH.
  - onehot() is computed at SEL_W width, then truncated to NUM_CH bits.
- Assertions for the verifier:
  - $onehot0(out_valid).
  - out_valid/out_data stable while out_valid[k] && !out_ready[k].
  - in_ready==0 whenever en==0.

Decomposition:
- Package demux_pkg: state enum {ST_EMPTY, ST_FULL}, plus a function sel_in_range(sel, num_ch).
- One combinational sub-module, decoder_n_to_m:
  - Parameters SEL_W, NUM_CH; inputs enable, sel; output onehot[NUM_CH].
  - Out-of-range sel gives all zeros.
  - Generalises the existing enable-gated decoders; the top instantiates it once for next-state out_valid.

Test Plan:
- Reset, then in_sel=3, in_data=0xA5, in_valid=1 for one cycle, out_ready=all ones -> next cycle out_valid=8'b0000_1000, out_data=0xA5; following cycle out_valid=0.
- Back-pressure: load ch 5 with out_ready[5]=0 for 4 cycles and out_ready[2]=1 -> out_valid=8'b0010_0000 held, in_ready=0, data stable. Then raise out_ready[5] with in_valid (sel=1, 0x3C) -> next cycle out_valid=8'b0000_0010, out_data=0x3C.
- Streaming: sel 0..7 on consecutive cycles, all ready -> out_valid walks one-hot 1,2,4,...,128 on consecutive cycles with no bubbles; in_ready stays 1.
- Non-power-of-2 (SEL_W=3, NUM_CH=6): send sel=6 -> in_ready=1, transaction dropped, out_valid stays 0, err_oor=1. Pulse err_clr -> err_oor=0. err_clr together with sel=7 -> err_oor stays 1.
- Enable gating: FULL on ch 4, en=0, out_ready[4]=1 -> transaction drains, in_ready=0 throughout, new in_valid ignored until en=1.
- Async reset while FULL on ch 7: assert rst_n=0 mid-cycle -> out_valid=0 immediately. After release, no out_valid without a new accept.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered one-hot demux.
// Holds the output-stage state encoding and the select range check.
package demux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_ch);
    return sel < num_ch;
  endfunction

endpackage

// File: rtl/decoder_n_to_m.sv
// Enable-gated SEL_W-to-NUM_CH one-hot decoder, purely combinational.
// Selects at or beyond NUM_CH decode to all zeros.
module decoder_n_to_m #(
  parameter int SEL_W  = 3,
  parameter int NUM_CH = 8
) (
  input  logic              enable,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] onehot
);

  localparam int FULL_W = 1 << SEL_W;

  logic [FULL_W-1:0] full_dec;

  // Decode at full select width, then truncate so out-of-range codes vanish.
  always_comb begin
    full_dec = '0;
    if (enable) begin
      full_dec[sel] = 1'b1;
    end
    onehot = full_dec[NUM_CH-1:0];
  end

endmodule

// File: rtl/demux_onehot_reg.sv
// Routes (sel, data) to one of NUM_CH channels through a single-entry valid/ready stage.
// Latency 1 cycle; in_ready follows the selected channel's out_ready so throughput is 1/cycle.
module demux_onehot_reg
  import demux_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err_oor,
  input  logic              err_clr
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]   out_valid_q, out_valid_d;
  logic                err_q, err_d;

  logic                drain;
  logic                accept;
  logic                in_rng;
  logic [NUM_CH-1:0]   sel_onehot;

  assign drain    = (state_q == ST_FULL) && out_ready[ch_q];
  // Gated by rst_n so the producer never sees ready while the block is held in reset.
  assign in_ready = rst_n && en && ((state_q == ST_EMPTY) || drain);
  assign accept   = in_valid && in_ready;
  assign in_rng   = sel_in_range(32'(in_sel), NUM_CH);

  decoder_n_to_m #(
    .SEL_W  (SEL_W),
    .NUM_CH (NUM_CH)
  ) u_dec (
    .enable (accept),
    .sel    (in_sel),
    .onehot (sel_onehot)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (err_clr) begin
      err_d = 1'b0;
    end
    if (drain) begin
      state_d     = ST_EMPTY;
      out_valid_d = '0;
    end
    // A dropped out-of-range select only happens when EMPTY or draining, so the drain above already settles the state.
    if (accept) begin
      if (in_rng) begin
        state_d     = ST_FULL;
        ch_d        = in_sel;
        data_d      = in_data;
        out_valid_d = sel_onehot;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      ch_q        <= '0;
      data_q      <= '0;
      out_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign err_oor   = err_q;

endmodule
